// File: rtl/lpi_rtl_pkg.sv
// Shared Q-channel LPI definitions: 3-bit state encoding (RhQLpiState order)
// and default handshake timing constants.
package lpi_rtl_pkg;

  localparam logic [2:0] LPI_ST_Q_STOPPED  = 3'd0;
  localparam logic [2:0] LPI_ST_Q_EXIT     = 3'd1;
  localparam logic [2:0] LPI_ST_Q_RUN      = 3'd2;
  localparam logic [2:0] LPI_ST_Q_REQUEST  = 3'd3;
  localparam logic [2:0] LPI_ST_Q_DENIED   = 3'd4;
  localparam logic [2:0] LPI_ST_Q_CONTINUE = 3'd5;

  localparam int LPI_IDLE_CYCLES_DEF  = 4;
  localparam int LPI_DENY_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    Q_STOPPED  = LPI_ST_Q_STOPPED,
    Q_EXIT     = LPI_ST_Q_EXIT,
    Q_RUN      = LPI_ST_Q_RUN,
    Q_REQUEST  = LPI_ST_Q_REQUEST,
    Q_DENIED   = LPI_ST_Q_DENIED,
    Q_CONTINUE = LPI_ST_Q_CONTINUE
  } rh_qlpi_state_e;

endpackage

// File: rtl/rh_qlpi_device_fsm_sync.sv
// Two-flop asynchronous-reset synchronizer for the qreqn request line.
module rh_qlpi_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/rh_qlpi_device_fsm.sv
// Device-side Q-channel LPI controller: accepts on sustained idleness, denies on timeout.
// Define RH_QLPI_SYNC_EN to insert a 2-flop synchronizer on an asynchronous qreqn.
module rh_qlpi_device_fsm
  import lpi_rtl_pkg::*;
#(
  parameter int IDLE_CYCLES  = LPI_IDLE_CYCLES_DEF,
  parameter int DENY_TIMEOUT = LPI_DENY_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       qreqn,
  output logic       qacceptn,
  output logic       qdeny,
  output logic       qactive,
  input  logic       busy_i,
  input  logic       wake_i,
  output logic       stopped_o,
  output logic [2:0] state_o,
  output logic       err_o
);

  localparam int CNT_W = $clog2(DENY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DENY_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic qreqn_s;

`ifdef RH_QLPI_SYNC_EN
  rh_qlpi_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (qreqn),
    .q      (qreqn_s)
  );
`else
  assign qreqn_s = qreqn;
`endif

  rh_qlpi_state_e   state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             qreqn_s_p1;
  logic             err_d;
  logic             qacceptn_d, qdeny_d, stopped_d;
  logic             qacceptn_q, qdeny_q, stopped_q, err_q, qactive_q;
  logic             idle, qreqn_rise, qreqn_fall;

  assign idle       = !busy_i && !wake_i;
  assign qreqn_rise = qreqn_s && !qreqn_s_p1;
  assign qreqn_fall = !qreqn_s && qreqn_s_p1;

  // Stage p0: next-state, counters and protocol checks
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      Q_STOPPED: begin
        if (qreqn_s) state_d = Q_EXIT;
      end
      Q_EXIT: begin
        state_d = Q_RUN;
        if (qreqn_fall) err_d = 1'b1;
      end
      Q_RUN: begin
        if (!qreqn_s) begin
          state_d    = Q_REQUEST;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
        end
      end
      Q_REQUEST: begin
        wait_cnt_d = sat_inc(wait_cnt_q);
        idle_cnt_d = idle ? sat_inc(idle_cnt_q) : '0;
        if (qreqn_rise) err_d = 1'b1;
        // Accept has priority when the timeout expires on the last idle cycle
        if (idle && (idle_cnt_q == IDLE_LAST)) begin
          state_d = Q_STOPPED;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = Q_DENIED;
        end
      end
      Q_DENIED: begin
        if (qreqn_s) state_d = Q_CONTINUE;
      end
      Q_CONTINUE: begin
        state_d = Q_RUN;
        if (qreqn_fall) err_d = 1'b1;
      end
      default: state_d = Q_STOPPED;
    endcase

    qacceptn_d = !((state_d == Q_STOPPED) || (state_d == Q_EXIT));
    qdeny_d    = (state_d == Q_DENIED) || (state_d == Q_CONTINUE);
    stopped_d  = (state_d == Q_STOPPED);
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= Q_STOPPED;
      idle_cnt_q <= '0;
      wait_cnt_q <= '0;
      qreqn_s_p1 <= 1'b0;
      qacceptn_q <= 1'b0;
      qdeny_q    <= 1'b0;
      stopped_q  <= 1'b1;
      err_q      <= 1'b0;
      qactive_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      qreqn_s_p1 <= qreqn_s;
      qacceptn_q <= qacceptn_d;
      qdeny_q    <= qdeny_d;
      stopped_q  <= stopped_d;
      err_q      <= err_d;
      qactive_q  <= busy_i | wake_i;
    end
  end

  assign qacceptn  = qacceptn_q;
  assign qdeny     = qdeny_q;
  assign stopped_o = stopped_q;
  assign err_o     = err_q;
  assign qactive   = qactive_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_rh_qlpi_device_fsm.sv
// Bench for rh_qlpi_device_fsm: directed handshakes plus randomized idle patterns
// checked against an event-level model of the accept/deny decision.
`timescale 1ns/1ps
module tb_rh_qlpi_device_fsm;

  localparam int IC = 4;
  localparam int DT = 16;
`ifdef RH_QLPI_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef enum logic [2:0] {
    QSTOPPED = 3'd0, QEXIT = 3'd1, QRUN = 3'd2,
    QREQUEST = 3'd3, QDENIED = 3'd4, QCONTINUE = 3'd5
  } lpi_state_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       qreqn = 1'b0;
  logic       busy_i = 1'b0;
  logic       wake_i = 1'b0;
  logic       qacceptn, qdeny, qactive, stopped_o, err_o;
  logic [2:0] state_o;

  int  errors = 0;
  int  checks = 0;
  bit  chk_act = 1'b0;
  bit  pat [0:63];

  always #5 clk = ~clk;

  rh_qlpi_device_fsm #(.IDLE_CYCLES(IC), .DENY_TIMEOUT(DT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .qreqn     (qreqn),
    .qacceptn  (qacceptn),
    .qdeny     (qdeny),
    .qactive   (qactive),
    .busy_i    (busy_i),
    .wake_i    (wake_i),
    .stopped_o (stopped_o),
    .state_o   (state_o),
    .err_o     (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input lpi_state_t st, input logic err_exp);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".qacceptn"}, 32'(qacceptn), 32'(!(st == QSTOPPED || st == QEXIT)));
    chk({tag, ".qdeny"}, 32'(qdeny), 32'(st == QDENIED || st == QCONTINUE));
    chk({tag, ".stopped"}, 32'(stopped_o), 32'(st == QSTOPPED));
    chk({tag, ".err"}, 32'(err_o), 32'(err_exp));
  endtask

  task automatic tick();
    logic exp_act;
    exp_act = busy_i | wake_i;
    @(posedge clk);
    #1;
    if (chk_act) chk("qactive", 32'(qactive), 32'(exp_act));
  endtask

  task automatic drive(input bit is_idle);
    int r;
    if (is_idle) begin
      busy_i = 1'b0;
      wake_i = 1'b0;
    end else begin
      r = $urandom_range(1, 3);
      busy_i = r[0];
      wake_i = r[1];
    end
  endtask

  // Decision = first QRequest cycle closing a run of IC idle cycles, else timeout at DT-1
  task automatic run_request(input string tag, output bit accepted);
    int k_dec;
    int run;
    bit acc;
    int k;
    lpi_state_t exp_st;
    run = 0;
    acc = 1'b0;
    k_dec = DT - 1;
    for (int i = 0; i < DT; i++) begin
      run = pat[i] ? run + 1 : 0;
      if (run >= IC) begin
        k_dec = i;
        acc = 1'b1;
        break;
      end
    end
    qreqn = 1'b0;
    for (int e = 1; e <= LAT + 2 + k_dec; e++) begin
      k = e - (LAT + 2);
      if (k >= 0) drive(pat[k]);
      else drive($urandom_range(0, 1) == 0);
      tick();
      if (e <= LAT) exp_st = QRUN;
      else if (e < LAT + 2 + k_dec) exp_st = QREQUEST;
      else exp_st = acc ? QSTOPPED : QDENIED;
      chk_outs(tag, exp_st, 1'b0);
    end
    busy_i = 1'b0;
    wake_i = 1'b0;
    accepted = acc;
  endtask

  task automatic run_exit(input string tag);
    qreqn = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) begin
      tick();
      chk_outs(tag, (e <= LAT) ? QSTOPPED : ((e == LAT + 1) ? QEXIT : QRUN), 1'b0);
    end
  endtask

  task automatic run_continue(input string tag);
    qreqn = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) begin
      tick();
      chk_outs(tag, (e <= LAT) ? QDENIED : ((e == LAT + 1) ? QCONTINUE : QRUN), 1'b0);
    end
  endtask

  initial begin
    bit acc;
    // Reset with qreqn low: quiescent, stopped
    #1 resetn = 1'b0;
    #1;
    chk_outs("reset_async", QSTOPPED, 1'b0);
    chk("reset_qactive", 32'(qactive), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    chk_act = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_outs("hold_stopped", QSTOPPED, 1'b0);
    end

    run_exit("exit0");

    // All cycles idle: accept after IC+LAT+1 edges
    for (int i = 0; i < 64; i++) pat[i] = 1'b1;
    run_request("accept_idle", acc);
    chk("accept_idle.outcome", 32'(acc), 32'd1);
    run_exit("exit1");

    // Always busy: deny after DT+LAT+1 edges, then continue
    for (int i = 0; i < 64; i++) pat[i] = 1'b0;
    run_request("deny_busy", acc);
    chk("deny_busy.outcome", 32'(acc), 32'd0);
    run_continue("cont0");

    // Busy pulse on 3rd QRequest cycle delays accept by 3 edges
    for (int i = 0; i < 64; i++) pat[i] = 1'b1;
    pat[2] = 1'b0;
    run_request("busy_pulse", acc);
    chk("busy_pulse.outcome", 32'(acc), 32'd1);
    run_exit("exit2");

    // Randomized idle patterns
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 64; i++) pat[i] = ($urandom_range(0, 4) != 0);
      if (t % 4 == 3) pat[$urandom_range(0, 3)] = 1'b0;
      run_request("rand", acc);
      if (acc) run_exit("rand_exit");
      else run_continue("rand_cont");
    end

    // qreqn rises in QRequest: single err pulse, decision unchanged
    busy_i = 1'b1;
    qreqn = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      tick();
      chk_outs("viol_enter", (e <= LAT) ? QRUN : QREQUEST, 1'b0);
    end
    qreqn = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      tick();
      chk_outs("viol_err", QREQUEST, e == LAT + 1);
    end
    for (int e = 1; e <= DT - LAT - 1; e++) begin
      tick();
      chk_outs("viol_wait", (e < DT - LAT - 1) ? QREQUEST : QDENIED, 1'b0);
    end
    busy_i = 1'b0;
    tick();
    chk_outs("viol_cont", QCONTINUE, 1'b0);
    tick();
    chk_outs("viol_run", QRUN, 1'b0);

    // Asynchronous reset while in QDenied
    for (int i = 0; i < 64; i++) pat[i] = 1'b0;
    run_request("deny_pre_reset", acc);
    #2;
    chk_act = 1'b0;
    resetn = 1'b0;
    #1;
    chk_outs("reset_in_denied", QSTOPPED, 1'b0);
    chk("reset_in_denied.qactive", 32'(qactive), 32'd0);
    tick();
    resetn = 1'b1;
    chk_act = 1'b1;
    tick();
    chk_outs("post_reset", QSTOPPED, 1'b0);
    run_exit("exit_post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
